// File: rtl/clk_gate_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_gate_ctrl_multi (+ tc_clk_gating leaf cell)                   |
// | Brief   : per-channel synchronised clock gate with busy-driven drain.       |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module tc_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic r_en_latch;

  // Transparent while clk_i is low, so the AND below cannot glitch.
  always_latch begin
    if (!clk_i) r_en_latch <= en_i | test_en_i;
  end

  assign clk_o = clk_i & r_en_latch;
endmodule

module clk_gate_ctrl_multi #(
  parameter int NumCh      = 4,
  parameter int SyncStages = 2,
  parameter int IdleCycles = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       test_en_i,
  input  logic [NumCh-1:0]           en_async_i,
  input  logic [NumCh-1:0]           busy_i,
  output logic [NumCh-1:0]           en_ack_o,
  output logic [NumCh-1:0]           clk_o,
  output logic [$clog2(NumCh+1)-1:0] active_cnt_o
);
  localparam int c_cnt_w = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
  localparam int c_act_w = $clog2(NumCh + 1);
  localparam logic [c_cnt_w-1:0] c_idle = c_cnt_w'(IdleCycles);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  logic [NumCh-1:0]   w_ge_nxt;
  logic [NumCh-1:0]   r_ge;
  logic [c_act_w-1:0] w_pop;
  logic [c_act_w-1:0] r_active_cnt;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic [SyncStages-1:0] r_sync;
    logic                  w_en_s;
    state_e                r_state;
    state_e                w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_sync <= '0;
      else         r_sync <= {r_sync[SyncStages-2:0], en_async_i[c]};
    end

    assign w_en_s = r_sync[SyncStages-1];

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_OFF: begin
          if (w_en_s) w_state_nxt = ST_ON;
        end
        ST_ON: begin
          if (!w_en_s) begin
            if (IdleCycles > 0) begin
              w_state_nxt = ST_DRAIN;
              w_cnt_nxt   = c_idle;
            end else begin
              w_state_nxt = ST_OFF;
            end
          end
        end
        ST_DRAIN: begin
          // A returning request wins over an expiring count.
          if (w_en_s) begin
            w_state_nxt = ST_ON;
          end else if (busy_i[c]) begin
            w_cnt_nxt = c_idle;
          end else if (r_cnt > c_one) begin
            w_cnt_nxt = r_cnt - c_one;
          end else begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_state <= ST_OFF;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    assign w_ge_nxt[c] = (w_state_nxt != ST_OFF);

    tc_clk_gating u_cg (
      .clk_i     (clk_i),
      .en_i      (r_ge[c]),
      .test_en_i (test_en_i),
      .clk_o     (clk_o[c])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NumCh; i++) begin
      w_pop = w_pop + c_act_w'(w_ge_nxt[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ge         <= '0;
      r_active_cnt <= '0;
    end else begin
      r_ge         <= w_ge_nxt;
      r_active_cnt <= w_pop;
    end
  end

  assign en_ack_o     = r_ge;
  assign active_cnt_o = r_active_cnt;
endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_clk_gate_ctrl_multi                                            |
// | Brief   : directed vector table plus latency/abort/reset sequences.         |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_clk_gate_ctrl_multi;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       test_en = 1'b0;
  logic [3:0] en_async = 4'h0;
  logic [3:0] busy = 4'h0;
  logic [3:0] ack;
  logic [3:0] clko;
  logic [2:0] act_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int rise0 = 0;
  int rise1 = 0;
  int rise2 = 0;

  clk_gate_ctrl_multi #(.NumCh(4), .SyncStages(2), .IdleCycles(8)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .test_en_i    (test_en),
    .en_async_i   (en_async),
    .busy_i       (busy),
    .en_ack_o     (ack),
    .clk_o        (clko),
    .active_cnt_o (act_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clko[0]) rise0++;
  always @(posedge clko[1]) rise1++;
  always @(posedge clko[2]) rise2++;

  typedef struct {
    logic [3:0] en;
    logic [3:0] busy;
    int         ncyc;
    logic [3:0] ack;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int gaps;

    //              en     busy   ncyc ack    cnt
    vecs[0]  = '{4'h0, 4'h0,  3, 4'h0, 3'd0};
    vecs[1]  = '{4'hB, 4'h0,  2, 4'h0, 3'd0};  // after edge k+1: still syncing
    vecs[2]  = '{4'hB, 4'h0,  1, 4'hB, 3'd3};  // after edge k+2: 0 -> 3 in one edge
    vecs[3]  = '{4'h9, 4'h0,  2, 4'hB, 3'd3};  // ch1 released, draining
    vecs[4]  = '{4'h9, 4'h0,  8, 4'hB, 3'd3};  // after j+9: still draining
    vecs[5]  = '{4'h9, 4'h0,  1, 4'h9, 3'd2};  // after j+10: ch1 off
    vecs[6]  = '{4'h0, 4'h0, 12, 4'h0, 3'd0};
    vecs[7]  = '{4'hF, 4'h0,  3, 4'hF, 3'd4};
    vecs[8]  = '{4'h0, 4'hF, 30, 4'hF, 3'd4};  // busy holds every drain
    vecs[9]  = '{4'h0, 4'h0,  7, 4'hF, 3'd4};  // after b+6: counter at 1
    vecs[10] = '{4'h0, 4'h0,  1, 4'h0, 3'd0};  // after b+7: all off

    // Reset state and DFT override
    @(negedge clk);
    @(posedge clk); #1;
    check("rst_clko_low", 32'(clko), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_cnt", 32'(act_cnt), 32'h0);
    @(negedge clk);
    test_en = 1'b1;
    @(posedge clk); #1;
    check("dft_clko_high", 32'(clko), 32'hF);
    @(negedge clk); #1;
    check("dft_clko_low", 32'(clko), 32'h0);
    check("dft_ack", 32'(ack), 32'h0);
    @(negedge clk);
    test_en = 1'b0;
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      en_async = vecs[i].en;
      busy     = vecs[i].busy;
      step(vecs[i].ncyc);
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d_cnt", i), 32'(act_cnt), 32'(vecs[i].cnt));
    end

    // Single-channel enable/release latency on ch1
    step(2);
    en_async = 4'h2;
    r = rise1;
    step(2);
    check("lat_ack_k1", 32'(ack[1]), 32'h0);
    step(1);
    check("lat_ack_k2", 32'(ack[1]), 32'h1);
    check("lat_no_rise_k2", 32'(rise1 - r), 32'h0);
    step(1);
    check("lat_first_rise_k3", 32'(rise1 - r), 32'h1);
    step(5);
    en_async = 4'h0;
    step(10);
    check("rel_ack_j9", 32'(ack[1]), 32'h1);
    r = rise1;
    step(1);
    check("rel_ack_j10", 32'(ack[1]), 32'h0);
    check("rel_last_rise_j10", 32'(rise1 - r), 32'h1);
    r = rise1;
    step(5);
    check("rel_no_more_rise", 32'(rise1 - r), 32'h0);

    // Drain abort on ch2 exactly when the counter sits at 1
    en_async = 4'h4;
    step(4);
    check("abort_on", 32'(ack[2]), 32'h1);
    en_async = 4'h0;
    r = rise2;
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ack[2] !== 1'b1) gaps++;
      if (i == 7) en_async = 4'h4;
    end
    check("abort_ack_gaps", 32'(gaps), 32'h0);
    check("abort_clk_rises", 32'(rise2 - r), 32'd20);
    en_async = 4'h0;
    step(12);
    check("abort_final_off", 32'(ack), 32'h0);

    // Reset in the middle of a drain, during clk high
    en_async = 4'h1;
    step(4);
    check("mid_on", 32'(ack[0]), 32'h1);
    en_async = 4'h0;
    step(6);
    check("mid_draining", 32'(ack[0]), 32'h1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("mid_ack_async", 32'(ack[0]), 32'h0);
    check("mid_cnt_async", 32'(act_cnt), 32'h0);
    check("mid_high_completes", 32'(clko[0]), 32'h1);
    r = rise0;
    step(3);
    check("mid_no_more_rise", 32'(rise0 - r), 32'h0);
    rstn = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/clk_gate_ctrl_multi.md
# clk_gate_ctrl_multi

Multi-channel clock-gate controller for the SoC clock tree. It generalises the single synchronised clock gate to NumCh independent channels. Each channel has an asynchronous enable request, a synchronous acknowledge and a busy-driven drain hysteresis, so a gated domain never loses its clock while it still has work in flight. Each channel drives one latch-based tc_clk_gating cell, and the block sits between the power/clock manager and the gated subsystem clocks.

## Interface
Parameters:
- NumCh, 4: number of independent gated clock channels (≥1).
- SyncStages, 2: flip-flop stages in each enable synchroniser (≥2).
- IdleCycles, 8: busy-free clock cycles a channel keeps running after the enable is withdrawn; 0 disables draining.

Ports:
- clk_i  in  1  source clock; all channels are derived from it.
- rstn_i  in  1  reset: asynchronous, active-low.
- test_en_i  in  1  DFT override; forces every clk_o running and does not affect the FSM or the acks.
- en_async_i  in  NumCh  per-channel enable request, asynchronous to clk_i.
- busy_i  in  NumCh  per-channel busy indication, synchronous to clk_i; holds off gating while high.
- en_ack_o  out  NumCh  per-channel acknowledge; high exactly while that channel's gate enable is high.
- clk_o  out  NumCh  gated clocks.
- active_cnt_o  out  $clog2(NumCh+1)  registered count of channels whose gate enable is high.

## Operation
- Per channel:
  - One SyncStages-deep synchroniser turns en_async_i[c] into en_s[c].
  - One FSM with states OFF, ON and DRAIN.
  - One counter, $clog2(IdleCycles+1) bits wide (minimum 1).
  - One registered gate enable ge_q[c].
- FSM transitions:
  - OFF -> ON when en_s=1.
  - ON -> DRAIN when en_s=0 and IdleCycles>0; the counter loads IdleCycles.
  - ON -> OFF when en_s=0 and IdleCycles=0.
  - DRAIN -> ON when en_s=1. This aborts the drain and takes priority over a count expiring in the same cycle.
  - DRAIN with busy_i=1: the counter reloads IdleCycles.
  - DRAIN with busy_i=0 and counter>1: the counter decrements.
  - DRAIN with busy_i=0 and counter==1: go to OFF.
- Gate enable and ack:
  - ge_q[c] is registered from the next-state decode: ge_q = (next_state != OFF).
  - en_ack_o[c] = ge_q[c].
- Clock output: clk_o[c] comes from a tc_clk_gating instance with E=ge_q[c], TE=test_en_i and CLK=clk_i. Because the latch is transparent while clk_i is low, the output is glitch-free.
- Count output: active_cnt_o is registered and equals the popcount of next-cycle ge_q. It updates on the same edge as ge_q.
- Channels are fully independent. Simultaneous requests and releases on different channels are all handled in the same cycle.
- busy_i is ignored in OFF and ON.

## Timing
- Reset values:
  - All FSMs OFF, synchronisers 0, counters 0.
  - en_ack_o=0, active_cnt_o=0.
  - clk_o=0 for test_en_i=0; clk_o=clk_i for test_en_i=1.
- Enable latency: en_async_i rises before edge k.
  - en_s=1 after edge k+SyncStages-1.
  - State ON, ge_q=1, ack=1 after edge k+SyncStages.
  - First clk_o rising edge at edge k+SyncStages+1.
- Release latency: en_async_i falls before edge k, with busy_i=0.
  - DRAIN after edge k+SyncStages.
  - OFF and ack=0 after edge k+SyncStages+IdleCycles.
  - Last clk_o rising edge is at that same edge.
- IdleCycles=0: ack falls after edge k+SyncStages.
- Enable pulses shorter than one clk_i period may be missed. Requesters must hold en_async_i until en_ack_o matches it.
- Reset mid-operation:
  - ge_q clears asynchronously.
  - A clk_o high phase already in progress completes; no further pulses follow.
  - The ack drops immediately.

## Test plan
- **Reset and DFT:** assert rstn_i with test_en_i=0 -> all clk_o low, acks 0, active_cnt_o=0. Raise test_en_i=1 -> all clk_o toggle, acks stay 0.
- **Single-channel latency** (SyncStages=2, IdleCycles=8): raise en_async_i[1] before edge 10 -> ack[1]=1 after edge 12, first clk_o[1] rise at edge 13. Drop it before edge 30 -> ack[1]=0 after edge 40, no clk_o[1] pulses after edge 40.
- **Busy hold-off:** release channel 0 and hold busy_i[0]=1 for 20 cycles during DRAIN -> clk_o[0] keeps toggling. Ack falls exactly 8 cycles after busy_i drops.
- **Drain abort:** re-raise en_async_i[2] when the counter is at 1 -> the channel returns to ON with no gap in clk_o[2] and ack never drops.
- **Multi-channel:** enable channels 0, 1 and 3 in the same cycle -> active_cnt_o goes 0->3 on a single edge. Release channel 1 -> active_cnt_o becomes 2 on its OFF edge.
- **Mid-drain reset:** assert rstn_i in mid-DRAIN during clk_i high -> the clk_o high phase completes, no further rise occurs, ack=0 immediately.
